// File: rtl/qr_result_serializer.sv
// Buffers per-group QR results (y_hat, R, last flag) and streams each one out
// as twelve 40-bit beats over a valid/ready interface, flagging dropped frames.
module qr_result_serializer #(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned BEAT_W = 40
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_vld,
    input  logic              i_last_data,
    input  logic [159:0]      i_y_hat,
    input  logic [319:0]      i_r,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [BEAT_W-1:0] o_data,
    output logic [3:0]        o_beat_idx,
    output logic              o_sof,
    output logic              o_eof,
    output logic              o_last_frame,
    output logic              o_overflow,
    output logic [3:0]        o_frame_cnt
);

    localparam int unsigned    PW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned    CW        = $clog2(DEPTH + 1);
    localparam int unsigned    EW        = 481;
    localparam logic [CW-1:0]  OCC_FULL  = CW'(DEPTH);
    localparam logic [PW-1:0]  PTR_MAX   = PW'(DEPTH - 1);
    localparam logic [3:0]     LAST_BEAT = 4'd11;
    localparam logic [3:0]     CNT_MAX   = 4'd9;

    typedef enum logic {
        ST_IDLE,
        ST_SEND
    } state_t;

    state_t          state_q, state_d;
    logic [EW-1:0]   mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   occ_q, occ_d;
    logic [3:0]      beat_q, beat_d;
    logic [3:0]      frame_cnt_q, frame_cnt_d;
    logic            ovf_q, ovf_d;
    logic [EW-1:0]   head;
    logic            send;
    logic            hs;
    logic            pop;
    logic            push;

    // Entry layout {last, r, y_hat} puts beat n at bits [40n +: 40].
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (push) begin
            mem_q[wr_ptr_q] <= {i_last_data, i_r, i_y_hat};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= ST_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            occ_q       <= '0;
            beat_q      <= '0;
            frame_cnt_q <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            occ_q       <= occ_d;
            beat_q      <= beat_d;
            frame_cnt_q <= frame_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

    always_comb begin
        head        = mem_q[rd_ptr_q];
        send        = (state_q == ST_SEND);
        hs          = send && i_ready;
        pop         = hs && (beat_q == LAST_BEAT);
        // A full buffer still accepts a strobe that lands on the final-beat pop.
        push        = i_rd_vld && ((occ_q != OCC_FULL) || pop);

        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        occ_d       = occ_q;
        beat_d      = beat_q;
        frame_cnt_d = frame_cnt_q;
        ovf_d       = ovf_q;

        if (i_rd_vld && !push) begin
            ovf_d = 1'b1;
        end
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PTR_MAX) ? '0 : wr_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            occ_d = occ_q + 1'b1;
        end else if (pop && !push) begin
            occ_d = occ_q - 1'b1;
        end
        if (hs) begin
            beat_d = pop ? '0 : beat_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d    = (rd_ptr_q == PTR_MAX) ? '0 : rd_ptr_q + 1'b1;
            frame_cnt_d = (head[EW-1] || (frame_cnt_q == CNT_MAX)) ? '0 : frame_cnt_q + 1'b1;
        end

        // Entering SEND on the capture edge gives a one-cycle strobe-to-beat latency.
        case (state_q)
            ST_IDLE: if ((occ_q != '0) || push) state_d = ST_SEND;
            ST_SEND: if (pop && (occ_d == '0))  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    assign o_valid      = send;
    assign o_data       = send ? head[32'(beat_q) * BEAT_W +: BEAT_W] : '0;
    assign o_beat_idx   = send ? beat_q : '0;
    assign o_sof        = send && (beat_q == 4'd0);
    assign o_eof        = send && (beat_q == LAST_BEAT);
    assign o_last_frame = send && (beat_q == LAST_BEAT) && head[EW-1];
    assign o_overflow   = ovf_q;
    assign o_frame_cnt  = frame_cnt_q;

endmodule
